uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single 56-bit packet TX port of uart_controller between three producers:
  - register-read responses (REG),
  - ADS sample packets (ADS),
  - MPR sample packets (MPR).
- Priority scheme: fixed priority for REG; round-robin between ADS and MPR.
- Captures one packet at a time, presents it to the controller, detects acceptance, waits for the serial send to finish, then grants the next requester.
- Keeps per-source sent counters and a sticky timeout flag for debug readout.

Parameters:
- TIMEOUT_CYCLES, 16'd4096, max cycles o_TX_VALID may stay high without acceptance before the packet is dropped.
- CNT_W, 16, width of the per-source saturating sent counters.

Ports:
- i_CLK  input  1  system clock
- i_RSTN  input  1  asynchronous active-low reset
- i_REG_DATA  input  56  register-response packet, header in [55:48]
- i_REG_VALID  input  1  REG packet pending
- o_REG_READY  output  1  one-cycle capture pulse for REG
- i_ADS_DATA  input  56  ADS packet
- i_ADS_VALID  input  1  ADS packet pending
- o_ADS_READY  output  1  one-cycle capture pulse for ADS
- i_MPR_DATA  input  56  MPR packet
- i_MPR_VALID  input  1  MPR packet pending
- o_MPR_READY  output  1  one-cycle capture pulse for MPR
- o_TX_DATA  output  56  to uart_controller i_UART_DATA_TX
- o_TX_VALID  output  1  to uart_controller i_UART_DATA_TX_VALID
- i_TX_READY  input  1  from uart_controller o_UART_DATA_TX_READY
- o_BUSY  output  1  high in any state other than ST_IDLE
- o_TIMEOUT  output  1  sticky, set on acceptance timeout
- i_TIMEOUT_CLR  input  1  synchronous clear of o_TIMEOUT
- o_REG_CNT, o_ADS_CNT, o_MPR_CNT  output  CNT_W each  packets accepted by the controller, per source, saturating

Behaviour:
- Reset (i_RSTN low, asynchronous):
  - all outputs 0, state ST_IDLE, round-robin pointer = ADS;
  - a reset during any state aborts the packet silently; no counters change.
- Requester handshake:
  - A source holds VALID and DATA until its READY pulse.
  - READY is a single-cycle registered pulse, asserted in the cycle after the arbiter samples VALID in ST_IDLE.
  - Data is captured on the same edge the pulse is asserted.
- ST_IDLE:
  - Acts only when i_TX_READY=1.
  - Arbitration order: REG first if i_REG_VALID.
  - Otherwise ADS/MPR round-robin. If both are valid, the pointer's source wins and the pointer toggles to the other source. If only one is valid, it wins and the pointer is set to the other source.
  - On a win: capture the winner's DATA into o_TX_DATA, pulse its READY, remember the source, go to ST_SEND.
  - If no source is valid, or i_TX_READY=0, stay in ST_IDLE.
- ST_SEND:
  - o_TX_VALID=1; the timeout counter starts at 0 and increments each cycle.
  - Acceptance is i_TX_READY sampled 0 while o_TX_VALID=1. The controller drops ready on the edge it captures. Ready may stay high for extra cycles while the controller services RX; valid is held through these.
  - On acceptance: o_TX_VALID←0, increment the remembered source's counter (saturate at all-ones), go to ST_WAIT_DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 without acceptance: o_TX_VALID←0, o_TIMEOUT←1, no counter increment, go to ST_IDLE.
- ST_WAIT_DONE:
  - Wait for i_TX_READY=1, which marks end of serialisation or an unknown-header discard.
  - Then go to ST_IDLE; the earliest new grant is the following cycle.
- o_TX_DATA is held stable from capture until the next capture.
- Headers are not inspected; unknown headers are forwarded and still counted.
- o_TIMEOUT: i_TIMEOUT_CLR clears it. If a set and a clear occur in the same cycle, set wins.
- Fairness guarantee: a continuously valid ADS or MPR source waits at most one packet of the other source, plus any REG traffic.

Test Plan:
- Reset mid-send: ADS packet in ST_SEND, pulse i_RSTN low.
  -> o_TX_VALID=0 asynchronously, counters stay 0, state ST_IDLE, no READY pulse after release.
- Single REG: i_REG_DATA=56'h61_0012_0000_0000, controller model drops ready 2 cycles after valid.
  -> o_REG_READY one pulse, o_TX_DATA matches, o_TX_VALID high exactly until ready low, o_REG_CNT=1.
- Contention: REG, ADS and MPR valid together, back to back.
  -> grant order REG, ADS, MPR. With ADS+MPR held valid for 6 packets: ADS,MPR,ADS,MPR,ADS,MPR; counts 3/3.
- RX stall: model keeps ready high 5 extra cycles after valid rises (servicing RX).
  -> valid held through the stall, single acceptance, counter +1 only.
- Timeout: TIMEOUT_CYCLES=8, model never drops ready.
  -> o_TX_VALID falls after 8 cycles, o_TIMEOUT=1, counters unchanged. A later i_TIMEOUT_CLR pulse clears it; next packet proceeds normally.
- Saturation: CNT_W=4, send 17 MPR packets.
  -> o_MPR_CNT stops at 4'hF.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the single 56-bit packet TX port of uart_controller between REG, ADS and MPR producers.
//   i_CLK, i_RSTN                    clock, asynchronous active-low reset
//   i_<SRC>_DATA, i_<SRC>_VALID      producer packet, held until o_<SRC>_READY pulses (SRC = REG, ADS, MPR)
//   o_<SRC>_READY                    one-cycle capture pulse for the granted producer
//   o_TX_DATA, o_TX_VALID            packet towards uart_controller
//   i_TX_READY                       uart_controller ready; a low sample while o_TX_VALID is high is acceptance
//   o_BUSY                           arbiter is not idle
//   o_TIMEOUT, i_TIMEOUT_CLR         sticky acceptance-timeout flag and its synchronous clear
//   o_<SRC>_CNT                      saturating count of packets accepted by the controller
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
    parameter int          CNT_W          = 16
) (
    input  logic             i_CLK,
    input  logic             i_RSTN,
    input  logic [55:0]      i_REG_DATA,
    input  logic             i_REG_VALID,
    output logic             o_REG_READY,
    input  logic [55:0]      i_ADS_DATA,
    input  logic             i_ADS_VALID,
    output logic             o_ADS_READY,
    input  logic [55:0]      i_MPR_DATA,
    input  logic             i_MPR_VALID,
    output logic             o_MPR_READY,
    output logic [55:0]      o_TX_DATA,
    output logic             o_TX_VALID,
    input  logic             i_TX_READY,
    output logic             o_BUSY,
    output logic             o_TIMEOUT,
    input  logic             i_TIMEOUT_CLR,
    output logic [CNT_W-1:0] o_REG_CNT,
    output logic [CNT_W-1:0] o_ADS_CNT,
    output logic [CNT_W-1:0] o_MPR_CNT
);
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       src_q, src_d;
    logic [2:0]       rdy_q, rdy_d;
    logic             rr_q, rr_d;
    logic [15:0]      tmo_q, tmo_d;
    logic [55:0]      tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic             accept;
    logic             ads_win;

    // src_q/rdy_q are one-hot {MPR, ADS, REG}; rr_q = 0 means ADS has the round-robin turn
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        rdy_d      = '0;
        rr_d       = rr_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        timeout_d  = timeout_q & ~i_TIMEOUT_CLR;
        accept     = 1'b0;
        ads_win    = i_ADS_VALID & (~i_MPR_VALID | ~rr_q);
        unique case (state_q)
            ST_IDLE: if (i_TX_READY && (i_REG_VALID || i_ADS_VALID || i_MPR_VALID)) begin
                state_d    = ST_SEND;
                tx_valid_d = 1'b1;
                tmo_d      = '0;
                src_d      = i_REG_VALID ? 3'b001 : ads_win ? 3'b010 : 3'b100;
                rdy_d      = src_d;
                tx_data_d  = i_REG_VALID ? i_REG_DATA : ads_win ? i_ADS_DATA : i_MPR_DATA;
                // the turn passes to whichever of ADS/MPR did not win; REG grants leave it alone
                rr_d       = i_REG_VALID ? rr_q : ads_win;
            end
            // the controller signals capture by dropping ready, so a low sample here is acceptance
            ST_SEND: if (!i_TX_READY) begin
                accept     = 1'b1;
                tx_valid_d = 1'b0;
                state_d    = ST_WAIT_DONE;
            end else if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
                tx_valid_d = 1'b0;
                timeout_d  = 1'b1;
                state_d    = ST_IDLE;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
            ST_WAIT_DONE: if (i_TX_READY) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        for (int i = 0; i < 3; i++)
            cnt_d[i] = (accept && src_q[i] && !(&cnt_q[i])) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            rdy_q      <= '0;
            rr_q       <= 1'b0;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            rdy_q      <= rdy_d;
            rr_q       <= rr_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_REG_READY = rdy_q[0];
    assign o_ADS_READY = rdy_q[1];
    assign o_MPR_READY = rdy_q[2];
    assign o_TX_DATA   = tx_data_q;
    assign o_TX_VALID  = tx_valid_q;
    assign o_BUSY      = state_q != ST_IDLE;
    assign o_TIMEOUT   = timeout_q;
    assign o_REG_CNT   = cnt_q[0];
    assign o_ADS_CNT   = cnt_q[1];
    assign o_MPR_CNT   = cnt_q[2];
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scenarios for uart_tx_arbiter against a rule-level arbitration and counter model.
module tb_uart_tx_arbiter;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [2:0][55:0] src_data  = '0;
    logic [2:0]       src_valid = '0;
    logic             tx_ready  = 1'b1;
    logic             tmo_clr   = 1'b0;
    logic [55:0]      tx_data;
    logic             tx_valid, busy, timeout, reg_ready, ads_ready, mpr_ready;
    logic [CW-1:0]    reg_cnt, ads_cnt, mpr_cnt;

    int checks = 0;
    int errors = 0;
    int rem [3];
    int exp_cnt [3];
    int mdl_ptr = 0;
    int accept_delay = 2;
    int busy_len = 2;
    int ctl_cnt = 0;
    int low_cnt = 0;
    int vcycles = 0;
    bit never = 1'b0;

    int               g_src [$];
    logic [2:0]       g_set [$];
    logic [2:0][55:0] g_dat [$];
    logic [55:0]      g_obs [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16'd8), .CNT_W(CW)) dut (
        .i_CLK(clk), .i_RSTN(rst_n),
        .i_REG_DATA(src_data[0]), .i_REG_VALID(src_valid[0]), .o_REG_READY(reg_ready),
        .i_ADS_DATA(src_data[1]), .i_ADS_VALID(src_valid[1]), .o_ADS_READY(ads_ready),
        .i_MPR_DATA(src_data[2]), .i_MPR_VALID(src_valid[2]), .o_MPR_READY(mpr_ready),
        .o_TX_DATA(tx_data), .o_TX_VALID(tx_valid), .i_TX_READY(tx_ready),
        .o_BUSY(busy), .o_TIMEOUT(timeout), .i_TIMEOUT_CLR(tmo_clr),
        .o_REG_CNT(reg_cnt), .o_ADS_CNT(ads_cnt), .o_MPR_CNT(mpr_cnt)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [55:0] rnd56();
        return {24'($urandom), $urandom};
    endfunction

    // REG always wins; between ADS and MPR the holder of the turn wins a tie, and the turn then passes to the loser
    function automatic int arb_model(input logic [2:0] v);
        int w;
        if (v[0]) return 0;
        w = (v[1] && v[2]) ? (mdl_ptr == 0 ? 1 : 2) : (v[1] ? 1 : 2);
        mdl_ptr = (w == 1) ? 1 : 0;
        return w;
    endfunction

    function automatic void model_accept(input int w);
        exp_cnt[w] = (exp_cnt[w] >= MAXC) ? MAXC : exp_cnt[w] + 1;
    endfunction

    task automatic clear_log();
        g_src.delete();
        g_set.delete();
        g_dat.delete();
        g_obs.delete();
        vcycles = 0;
    endtask

    task automatic load(input int s, input int n);
        rem[s] = n;
        src_data[s] = rnd56();
        src_valid[s] = 1'b1;
    endtask

    // one clock: log grants, run the producers and the controller model
    task automatic cycle();
        logic [2:0]       pre_v;
        logic [2:0][55:0] pre_d;
        logic [2:0]       rdy;
        pre_v = src_valid;
        pre_d = src_data;
        @(posedge clk);
        #1;
        rdy = {mpr_ready, ads_ready, reg_ready};
        if (rdy != 3'b000) begin
            g_src.push_back($countones(rdy) == 1 ? (rdy[0] ? 0 : rdy[1] ? 1 : 2) : 3);
            g_set.push_back(pre_v);
            g_dat.push_back(pre_d);
            g_obs.push_back(tx_data);
        end
        for (int s = 0; s < 3; s++)
            if (rdy[s]) begin
                if (rem[s] > 1) begin
                    rem[s]--;
                    src_data[s] = rnd56();
                end else begin
                    rem[s] = 0;
                    src_valid[s] = 1'b0;
                end
            end
        if (tx_valid) vcycles++;
        if (!tx_ready) begin
            low_cnt--;
            ctl_cnt = 0;
            if (low_cnt <= 0) tx_ready = 1'b1;
        end else if (tx_valid) begin
            ctl_cnt++;
            if (!never && ctl_cnt == accept_delay) begin
                tx_ready = 1'b0;
                low_cnt = busy_len;
            end
        end else begin
            ctl_cnt = 0;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(src_valid == 3'b000 && !busy && tx_ready) && n < budget);
        ok = (src_valid == 3'b000 && !busy && tx_ready);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx_valid, busy, timeout, reg_ready, ads_ready, mpr_ready} !== 6'b0 || tx_data !== 56'h0)
            begin errors++; $display("FAIL reset_outputs: got valid=%b busy=%b tmo=%b rdy=%b%b%b data=%h, expected all zero", tx_valid, busy, timeout, reg_ready, ads_ready, mpr_ready, tx_data); end
        checks++;
        if (reg_cnt !== 0 || ads_cnt !== 0 || mpr_cnt !== 0)
            begin errors++; $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", reg_cnt, ads_cnt, mpr_cnt); end
        rst_n = 1'b1;
        mdl_ptr = 0;
        exp_cnt = '{0, 0, 0};
    endtask

    task automatic test_reset_mid_send();
        int n = 0;
        never = 1'b1;
        clear_log();
        load(1, 1);
        while (!tx_valid && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_send_reach: got valid=%b expected 1", tx_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL async_reset: got valid=%b busy=%b expected 0/0", tx_valid, busy); end
        #3 rst_n = 1'b1;
        mdl_ptr = 0;
        never = 1'b0;
        ctl_cnt = 0;
        tx_ready = 1'b1;
        clear_log();
        repeat (6) cycle();
        checks++;
        if (g_src.size() != 0 || busy !== 1'b0 || int'(ads_cnt) != exp_cnt[1])
            begin errors++; $display("FAIL after_reset: got grants=%0d busy=%b ads_cnt=%0d expected 0/0/%0d", g_src.size(), busy, ads_cnt, exp_cnt[1]); end
    endtask

    task automatic test_single_reg();
        bit ok;
        accept_delay = 2;
        busy_len = 3;
        never = 1'b0;
        clear_log();
        load(0, 1);
        src_data[0] = 56'h61_0012_0000_0000;
        wait_idle(50, ok);
        checks++;
        if (!ok || g_src.size() != 1 || g_src[0] != 0)
            begin errors++; $display("FAIL reg_grant: got ok=%b grants=%0d src=%0d expected 1 grant of REG(0)", ok, g_src.size(), g_src.size() ? g_src[0] : -1); end
        checks++;
        if (g_obs.size() != 1 || g_obs[0] !== 56'h61_0012_0000_0000 || tx_data !== 56'h61_0012_0000_0000)
            begin errors++; $display("FAIL reg_data: got %h expected 61001200000000", tx_data); end
        checks++;
        if (vcycles != 2) begin errors++; $display("FAIL reg_valid_len: got %0d expected 2", vcycles); end
        foreach (g_set[k]) model_accept(arb_model(g_set[k]));
        checks++;
        if (int'(reg_cnt) != exp_cnt[0] || int'(ads_cnt) != exp_cnt[1] || int'(mpr_cnt) != exp_cnt[2])
            begin errors++; $display("FAIL reg_count: got %0d/%0d/%0d expected %0d/%0d/%0d", reg_cnt, ads_cnt, mpr_cnt, exp_cnt[0], exp_cnt[1], exp_cnt[2]); end
    endtask

    task automatic test_contention();
        bit ok;
        int bad = 0;
        int w;
        int ord [7] = '{0, 1, 2, 1, 2, 1, 2};
        accept_delay = $urandom_range(1, 6);
        busy_len = $urandom_range(1, 4);
        clear_log();
        load(0, 1);
        load(1, 3);
        load(2, 3);
        wait_idle(400, ok);
        checks++;
        if (!ok || g_src.size() != 7) begin errors++; $display("FAIL cont_grants: got ok=%b grants=%0d expected 7", ok, g_src.size()); end
        for (int k = 0; k < g_src.size(); k++) begin
            w = arb_model(g_set[k]);
            if (g_src[k] != w || (k < 7 && g_src[k] != ord[k]) || g_obs[k] !== g_dat[k][w]) bad++;
            model_accept(w);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL cont_order: got %0d wrong grants expected 0", bad); end
        checks++;
        if (int'(reg_cnt) != exp_cnt[0] || int'(ads_cnt) != exp_cnt[1] || int'(mpr_cnt) != exp_cnt[2])
            begin errors++; $display("FAIL cont_counts: got %0d/%0d/%0d expected %0d/%0d/%0d", reg_cnt, ads_cnt, mpr_cnt, exp_cnt[0], exp_cnt[1], exp_cnt[2]); end
        checks++;
        if (vcycles != 7 * accept_delay) begin errors++; $display("FAIL cont_valid_len: got %0d expected %0d", vcycles, 7 * accept_delay); end
    endtask

    task automatic test_rx_stall();
        bit ok;
        accept_delay = 7;
        busy_len = 2;
        clear_log();
        load(2, 1);
        wait_idle(60, ok);
        checks++;
        if (!ok || g_src.size() != 1 || g_src[0] != 2 || vcycles != 7)
            begin errors++; $display("FAIL rx_stall: got ok=%b grants=%0d valid_len=%0d expected 1 MPR grant, 7 cycles", ok, g_src.size(), vcycles); end
        foreach (g_set[k]) model_accept(arb_model(g_set[k]));
        checks++;
        if (int'(mpr_cnt) != exp_cnt[2] || timeout !== 1'b0)
            begin errors++; $display("FAIL rx_stall_count: got cnt=%0d tmo=%b expected %0d/0", mpr_cnt, timeout, exp_cnt[2]); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        never = 1'b1;
        clear_log();
        load(1, 1);
        wait_idle(60, ok);
        checks++;
        if (!ok || vcycles != 8) begin errors++; $display("FAIL tmo_len: got ok=%b valid_len=%0d expected 8", ok, vcycles); end
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b expected 1", timeout); end
        foreach (g_set[k]) void'(arb_model(g_set[k]));
        checks++;
        if (int'(reg_cnt) != exp_cnt[0] || int'(ads_cnt) != exp_cnt[1] || int'(mpr_cnt) != exp_cnt[2])
            begin errors++; $display("FAIL tmo_counts: got %0d/%0d/%0d expected %0d/%0d/%0d", reg_cnt, ads_cnt, mpr_cnt, exp_cnt[0], exp_cnt[1], exp_cnt[2]); end
        tmo_clr = 1'b1;
        cycle();
        tmo_clr = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", timeout); end
        never = 1'b0;
        accept_delay = 3;
        busy_len = 2;
        clear_log();
        load(1, 1);
        wait_idle(60, ok);
        foreach (g_set[k]) model_accept(arb_model(g_set[k]));
        checks++;
        if (!ok || vcycles != 3 || int'(ads_cnt) != exp_cnt[1] || timeout !== 1'b0)
            begin errors++; $display("FAIL tmo_recover: got ok=%b len=%0d cnt=%0d tmo=%b expected 1/3/%0d/0", ok, vcycles, ads_cnt, timeout, exp_cnt[1]); end
        never = 1'b1;
        tmo_clr = 1'b1;
        clear_log();
        load(2, 1);
        do begin
            cycle();
            n++;
        end while (!(vcycles > 0 && !tx_valid) && n < 60);
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_set_wins: got %b expected 1", timeout); end
        cycle();
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_held_clear: got %b expected 0", timeout); end
        tmo_clr = 1'b0;
        never = 1'b0;
        foreach (g_set[k]) void'(arb_model(g_set[k]));
        checks++;
        if (int'(mpr_cnt) != exp_cnt[2] || busy !== 1'b0)
            begin errors++; $display("FAIL tmo2_counts: got cnt=%0d busy=%b expected %0d/0", mpr_cnt, busy, exp_cnt[2]); end
    endtask

    task automatic test_saturation();
        bit ok;
        int bad = 0;
        accept_delay = $urandom_range(1, 6);
        busy_len = $urandom_range(1, 3);
        clear_log();
        load(2, 17);
        wait_idle(800, ok);
        foreach (g_src[k]) begin
            if (g_src[k] != 2 || g_obs[k] !== g_dat[k][2]) bad++;
            model_accept(arb_model(g_set[k]));
        end
        checks++;
        if (!ok || g_src.size() != 17 || bad != 0)
            begin errors++; $display("FAIL sat_grants: got ok=%b grants=%0d bad=%0d expected 17 MPR grants", ok, g_src.size(), bad); end
        checks++;
        if (mpr_cnt !== 4'hF || int'(mpr_cnt) != exp_cnt[2])
            begin errors++; $display("FAIL sat_count: got %0d expected 15", mpr_cnt); end
    endtask

    task automatic test_random();
        bit ok;
        int n [3];
        int off [3];
        int tot, w, bad;
        for (int r = 0; r < 15; r++) begin
            accept_delay = $urandom_range(1, 6);
            busy_len = $urandom_range(1, 4);
            never = 1'b0;
            clear_log();
            tot = 0;
            for (int s = 0; s < 3; s++) begin
                n[s] = $urandom_range(0, 3);
                off[s] = $urandom_range(0, 4);
                tot += n[s];
            end
            for (int c = 0; c < 5; c++) begin
                for (int s = 0; s < 3; s++)
                    if (off[s] == c && n[s] > 0) load(s, n[s]);
                cycle();
            end
            wait_idle(500, ok);
            checks++;
            if (!ok || g_src.size() != tot)
                begin errors++; $display("FAIL rnd_grants[%0d]: got ok=%b grants=%0d expected %0d", r, ok, g_src.size(), tot); end
            bad = 0;
            for (int k = 0; k < g_src.size(); k++) begin
                w = arb_model(g_set[k]);
                if (g_src[k] != w || g_obs[k] !== g_dat[k][w]) bad++;
                model_accept(w);
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rnd_order[%0d]: got %0d wrong grants expected 0", r, bad); end
            checks++;
            if (int'(reg_cnt) != exp_cnt[0] || int'(ads_cnt) != exp_cnt[1] || int'(mpr_cnt) != exp_cnt[2])
                begin errors++; $display("FAIL rnd_counts[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", r, reg_cnt, ads_cnt, mpr_cnt, exp_cnt[0], exp_cnt[1], exp_cnt[2]); end
            checks++;
            if (vcycles != tot * accept_delay)
                begin errors++; $display("FAIL rnd_valid_len[%0d]: got %0d expected %0d", r, vcycles, tot * accept_delay); end
        end
    endtask

    initial begin
        rem = '{0, 0, 0};
        exp_cnt = '{0, 0, 0};
        test_reset();
        test_reset_mid_send();
        test_single_reg();
        test_contention();
        test_rx_stall();
        test_timeout();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
